fetch_stage: RTL
================

# fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the RISC pipeline. Owns the program counter and drives instruction memory. Assembles two-word instructions (LDM plus its 16-bit immediate) into a single IF/ID entry, and injects interrupt bubbles. Its registered outputs feed the decode stage and the phase-1 control unit directly: opcode field, immediate and interrupt flag.

## Interface
- ADDR_WIDTH, 16, program counter and instruction-memory address width.
- RESET_PC, 0, PC value loaded on reset.
- INT_VECTOR, 16'h0002, PC loaded when an interrupt is taken.
- i_clk  input  1  clock; all state updates on its rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_imem_data  input  16  instruction word at o_imem_addr, valid in the same cycle (combinational read).
- o_imem_addr  output  ADDR_WIDTH  current PC.
- i_stall  input  1  hazard stall from decode; freezes the stage.
- i_branch  input  1  redirect request from a later stage.
- i_branch_target  input  ADDR_WIDTH  redirect destination.
- i_interrupt  input  1  external interrupt request, one-cycle pulse or level.
- o_instruction  output  16  IF/ID instruction; opcode is bits [15:13].
- o_immediate  output  16  IF/ID immediate; 0 for single-word instructions.
- o_pc  output  ADDR_WIDTH  address of the instruction's first word; for an interrupt bubble, the return address.
- o_valid  output  1  IF/ID entry holds a real instruction or an interrupt bubble.
- o_interrupt  output  1  IF/ID entry is an interrupt bubble.

## Operation
- NOP encoding is 16'hA000 (opcode 101). LDM is opcode 001 and is the only two-word instruction.
- State machine states:
  - FETCH: normal fetch.
  - IMM: fetching the LDM immediate; the first word is held in an internal register.
- Event priority, highest first: reset > i_branch > i_stall > interrupt take > normal fetch.
- FETCH, single-word instruction:
  - IF/ID loads instruction = i_imem_data, immediate = 0, pc = PC, valid = 1, interrupt = 0.
  - PC <= PC+1.
- FETCH, opcode 001:
  - Hold the word and its PC internally; PC <= PC+1; go to IMM.
  - IF/ID loads a bubble: NOP, valid = 0.
- IMM:
  - IF/ID loads instruction = held word, immediate = i_imem_data, pc = held PC, valid = 1.
  - PC <= PC+1; go to FETCH.
- i_branch:
  - PC <= i_branch_target; state <= FETCH; any held LDM word is discarded.
  - IF/ID loads a bubble.
  - Applies even when i_stall = 1.
- i_stall without branch:
  - PC, state, held word and all IF/ID outputs keep their values.
  - The pending interrupt flag can still be set.
- Interrupt:
  - i_interrupt sets a pending flag.
  - The interrupt is taken only in FETCH with no stall and no branch.
  - On take: IF/ID loads instruction = NOP, immediate = 0, pc = PC (not incremented), valid = 1, interrupt = 1.
  - On take: PC <= INT_VECTOR and the pending flag clears.
  - An interrupt is never taken between the two LDM words.
  - A request arriving in the same cycle as a take re-sets the pending flag.
- PC arithmetic is modulo 2^ADDR_WIDTH; PC+1 at all-ones wraps to 0, including in mid-LDM.

## Timing
- Reset (synchronous, i_reset high at a rising edge):
  - PC = RESET_PC, state = FETCH, pending = 0.
  - o_instruction = 16'hA000, o_immediate = 0, o_pc = 0, o_valid = 0, o_interrupt = 0.
- Reset asserted mid-LDM discards the held word.
- o_imem_addr equals PC combinationally and is RESET_PC in the first cycle after reset.
- Latency: a word at address A appears on IF/ID one cycle after PC = A. An LDM appears one cycle after its immediate is fetched, i.e. 2 cycles after PC = A.
- Redirect: the target word is fetched in the cycle after i_branch and appears on IF/ID one cycle later.
- Throughput: 1 instruction per cycle for single-word code; LDM costs 2 cycles.
- Interrupt latency: the bubble appears at the first qualifying FETCH edge after the request. The vector word is fetched in the following cycle.

## Configuration
- FETCH_INTERRUPT_EN defined: interrupt logic present as described above.
- FETCH_INTERRUPT_EN undefined:
  - The pending flag and take path are removed; i_interrupt is ignored.
  - o_interrupt is constant 0; PC never loads INT_VECTOR.
  - All other behaviour is identical.

## Test plan
- Reset, then memory 0: 16'h6000, 1: 16'h8000 -> IF/ID shows (6000, pc 0, valid 1), then (8000, pc 1); o_imem_addr counts 0, 1, 2.
- LDM 16'h2000 at 4, immediate 16'hBEEF at 5 -> one valid-0 NOP bubble, then instruction 2000, immediate BEEF, pc 4, valid 1; next fetch from 6.
- i_stall high for 3 cycles at PC 7 -> o_imem_addr stays 7 and IF/ID unchanged; i_branch to 16'h0040 during the stall -> bubble, then fetch from 0x40.
- i_interrupt pulse during the LDM IMM cycle at PC 9 -> LDM completes, then bubble with o_interrupt = 1 and o_pc = 10; next fetch from 0x0002.
- PC = 16'hFFFF with LDM -> immediate fetched from 0x0000; IF/ID pc = FFFF; next fetch from 1.
- i_reset asserted in IMM state -> all outputs take their reset values next cycle; fetch restarts at RESET_PC in FETCH state.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction-memory port, redirect/stall/interrupt controls
// from the rest of the pipeline, and the IF/ID register outputs.
interface fetch_stage_if #(
  parameter int ADDR_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [15:0]           imem_data;
  logic                  stall;
  logic                  branch;
  logic [ADDR_WIDTH-1:0] branch_target;
  logic                  interrupt_req;
  logic [15:0]           instruction;
  logic [15:0]           immediate;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  valid;
  logic                  interrupt;

  modport master (
    output imem_addr, instruction, immediate, pc, valid, interrupt,
    input  imem_data, stall, branch, branch_target, interrupt_req
  );

  modport slave (
    input  imem_addr, instruction, immediate, pc, valid, interrupt,
    output imem_data, stall, branch, branch_target, interrupt_req
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch + IF/ID register: PC, LDM two-word assembly, interrupt bubbles.
// Interrupt take path is built only when FETCH_INTERRUPT_EN is defined.
module fetch_stage #(
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [ADDR_WIDTH-1:0] INT_VECTOR = 'h0002
) (
  input  logic          i_clk,
  input  logic          i_reset,
  fetch_stage_if.master bus
);
  localparam logic [15:0] NOP    = 16'hA000;
  localparam logic [2:0]  OP_LDM = 3'b001;

  typedef enum logic {FETCH, IMM} state_t;

  typedef struct packed {
    logic [15:0]           instr;
    logic [15:0]           imm;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  valid;
    logic                  intr;
  } ifid_t;

  state_t                state_q, state_n;
  logic [ADDR_WIDTH-1:0] pc_q, pc_n, pc_inc;
  logic [15:0]           held_word_q, held_word_n;
  logic [ADDR_WIDTH-1:0] held_pc_q, held_pc_n;
  ifid_t                 ifid_q, ifid_n;
  logic                  take;

  assign pc_inc = pc_q + ADDR_WIDTH'(1);

`ifdef FETCH_INTERRUPT_EN
  logic pend_q, pend_n;

  // Take only from pending so a same-cycle request re-arms the flag.
  assign take   = pend_q && (state_q == FETCH) && !bus.stall && !bus.branch;
  assign pend_n = (pend_q && !take) || bus.interrupt_req;

  always_ff @(posedge i_clk) begin
    if (i_reset) pend_q <= 1'b0;
    else         pend_q <= pend_n;
  end
`else
  logic unused_interrupt_req;
  assign unused_interrupt_req = bus.interrupt_req;
  assign take = 1'b0;
`endif

  always_comb begin
    state_n     = state_q;
    pc_n        = pc_q;
    held_word_n = held_word_q;
    held_pc_n   = held_pc_q;
    ifid_n      = ifid_q;
    if (bus.branch) begin
      pc_n    = bus.branch_target;
      state_n = FETCH;
      ifid_n  = '{instr: NOP, imm: '0, pc: pc_q, valid: 1'b0, intr: 1'b0};
    end else if (!bus.stall) begin
      if (take) begin
        pc_n   = INT_VECTOR;
        ifid_n = '{instr: NOP, imm: '0, pc: pc_q, valid: 1'b1, intr: 1'b1};
      end else begin
        pc_n = pc_inc;
        case (state_q)
          FETCH: begin
            if (bus.imem_data[15:13] == OP_LDM) begin
              held_word_n = bus.imem_data;
              held_pc_n   = pc_q;
              state_n     = IMM;
              ifid_n      = '{instr: NOP, imm: '0, pc: pc_q, valid: 1'b0, intr: 1'b0};
            end else begin
              ifid_n = '{instr: bus.imem_data, imm: '0, pc: pc_q, valid: 1'b1, intr: 1'b0};
            end
          end
          IMM: begin
            state_n = FETCH;
            ifid_n  = '{instr: held_word_q, imm: bus.imem_data, pc: held_pc_q,
                        valid: 1'b1, intr: 1'b0};
          end
          default: state_n = FETCH;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      held_word_q <= NOP;
      held_pc_q   <= '0;
      ifid_q      <= '{instr: NOP, imm: '0, pc: '0, valid: 1'b0, intr: 1'b0};
    end else begin
      state_q     <= state_n;
      pc_q        <= pc_n;
      held_word_q <= held_word_n;
      held_pc_q   <= held_pc_n;
      ifid_q      <= ifid_n;
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.instruction = ifid_q.instr;
  assign bus.immediate   = ifid_q.imm;
  assign bus.pc          = ifid_q.pc;
  assign bus.valid       = ifid_q.valid;
`ifdef FETCH_INTERRUPT_EN
  assign bus.interrupt   = ifid_q.intr;
`else
  assign bus.interrupt   = 1'b0;
`endif
endmodule
